// File: rtl/mbox_reg_frontend.sv
// mbox_reg_frontend
//   Register-bus front end for the mailbox register file. Accepts one
//   valid/ready request at a time, decodes the word address, drives one-cycle
//   write/read strobes plus read-modify-write merged data into the subreg
//   slices, and returns captured read data or a decode error on a valid/ready
//   response channel.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      request handshake
//   req_addr_i                   byte address (AW bits)
//   req_write_i                  1 = write, 0 = read
//   req_wdata_i, req_be_i        write data and byte enables
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_error_o     read data (0 for writes/errors), decode error
//   reg_we_o, reg_re_o           one-hot write / read strobes per register
//   reg_wd_o                     merged write data to the subreg wd inputs
//   reg_qs_i                     readback, register i at [i*DW +: DW]
module mbox_reg_frontend #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 32,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AW-1:0]          req_addr_i,
  input  logic                   req_write_i,
  input  logic [DW-1:0]          req_wdata_i,
  input  logic [DW/8-1:0]        req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [DW-1:0]          reg_wd_o,
  input  logic [NUM_REGS*DW-1:0] reg_qs_i
);

  localparam int unsigned IW = AW - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]      state;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] be_q;
  logic [DW-1:0]   rdata_q;
  logic            error_q;

  logic [IW-1:0]   idx;
  logic            dec_err;
  logic [DW-1:0]   qs_sel;
  logic [DW-1:0]   mask;
  logic            in_access;

  assign idx       = addr_q[AW-1:2];
  assign in_access = (state == ACCESS) && !rst_i;

  // Out-of-range indices select 0 rather than slicing past reg_qs_i.
  always_comb begin
    qs_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IW'(i)) qs_sel = reg_qs_i[i*DW +: DW];
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned b = 0; b < DW/8; b++) begin
      mask[b*8 +: 8] = {8{be_q[b]}};
    end
  end

  assign dec_err = (addr_q[1:0] != 2'b00) || !(32'(idx) < NUM_REGS);

  always_comb begin
    reg_we_o = '0;
    reg_re_o = '0;
    reg_wd_o = '0;
    if (in_access) begin
      reg_wd_o = (qs_sel & ~mask) | (wdata_q & mask);
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (!dec_err && idx == IW'(i)) begin
          reg_we_o[i] = write_q && (be_q != '0);
          reg_re_o[i] = !write_q;
        end
      end
    end
  end

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign rsp_valid_o = (state == RESP) && !rst_i;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            write_q <= req_write_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // Captured on the same edge the RC subreg clears, so this is the
          // pre-clear value.
          rdata_q <= (!dec_err && !write_q) ? qs_sel : '0;
          error_q <= dec_err;
          state   <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
